alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the ALU/divider interface: accepts one operation per start/done transaction
//  from the control unit and drives the ALU's opcode, operands and divider clock-enable.
//  Holds ALU inputs stable for the divider's pipeline latency, then captures the ALU result.
//  Sits between the Sextium control FSM and the combinational ALU (ALU instantiated by parent).
// PARAMETERS
//  WIDTH    16  datapath width; must match the ALU's WIDTH
//  DIV_LAT  4   divider pipeline depth in enabled clocks (>=1)
// PORTS
//  clock        in   1      system clock, rising edge
//  reset        in   1      asynchronous, active-high reset
//  start        in   1      request; sampled only in IDLE
//  op           in   3      000 add, 001 sub, 010 mul, 011 div, 100 shift, 101 nand, 11x invalid
//  opa          in   WIDTH  operand A (ALU dataa; divisor for div)
//  opb          in   WIDTH  operand B (ALU datab; dividend for div)
//  busy         out  1      high from accept until done cycle inclusive
//  done         out  1      one-cycle pulse, res valid in same cycle
//  res          out  WIDTH  registered result, held until next done
//  div_zero     out  1      registered with res: div requested with opa==0
//  alu_s        out  3      to ALU s
//  alu_a        out  WIDTH  to ALU dataa
//  alu_b        out  WIDTH  to ALU datab
//  alu_diven    out  1      to ALU diven (divider clken)
//  alu_result   in   WIDTH  from ALU result
// BEHAVIOUR
//  Reset: state=IDLE; busy=0, done=0, res=0, div_zero=0, alu_s=0, alu_a=0, alu_b=0, alu_diven=0, cnt=0.
//  FSM states: IDLE, EXEC, DIVW, DONE.
//  IDLE: start=1 at edge T -> latch op/opa/opb into alu_s/alu_a/alu_b; busy=1.
//    op=011 & opa!=0 -> DIVW, alu_diven=1, cnt=DIV_LAT-1. op=011 & opa==0 -> EXEC (no divider use).
//    otherwise -> EXEC.
//  EXEC (1 cycle): at edge capture res=alu_result (res=0 for op 11x or div-by-zero);
//    div_zero=(op==011 & opa==0); -> DONE. Latency start->done = 2 edges.
//  DIVW: alu_diven=1 and alu_a/alu_b/alu_s held constant; cnt decrements each edge;
//    at cnt==0 edge: res=alu_result (quotient opb/opa, truncating toward zero), div_zero=0,
//    alu_diven=0, -> DONE. Latency start->done = DIV_LAT+1 edges; diven high exactly DIV_LAT cycles.
//  DONE (1 cycle): done=1, busy=1; next edge -> IDLE, busy=0. start in DONE ignored (no back-to-back).
//  start while busy: ignored, no queuing; op/opa/opb changes while busy have no effect.
//  Shift/mul/add/sub wrap per ALU (WIDTH-bit truncation); sequencer adds no arithmetic.
//  Holding diven DIV_LAT cycles flushes stale divider contents; no pipeline drain needed.
//  Reset mid-DIVW: immediate return to IDLE, diven=0, partial result discarded, done never pulses.
//  alu_a/alu_b/alu_s retain last operation's values in IDLE (only start loads them).
// STRUCTURE
//  Shared header alu_defs.vh: opcode constants ALU_ADD..ALU_NAND, ALU_DIV; FSM state encodings.
//  Single module; no sub-module; down-counter width $clog2(DIV_LAT)+1. ALU instantiated by parent.
// TESTING (bench instantiates alu + alu_sequencer, DIV_LAT=4)
//  add: opa=7, opb=5, start 1 cycle -> done 2 edges later, res=12, div_zero=0.
//  div: op=011, opa=3, opb=-10 -> alu_diven high 4 cycles, done at edge 5, res=-3.
//  div by zero: op=011, opa=0, opb=9 -> done at edge 2, res=0, div_zero=1, diven never high.
//  shift: op=100, opa=16'h0001, opb=-1 -> res=0; opb=4 -> res=16'h0010.
//  start held high / pulsed during DIVW -> exactly one done per accepted request; res unchanged.
//  reset asserted at DIVW cycle 2 -> all outputs 0 asynchronously; next div opa=2,opb=8 -> res=4.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer: opcode values and FSM states.
package alu_sequencer_pkg;

    // Opcode that routes through the pipelined divider.
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DIVW,
        ST_DONE
    } state_t;

    // Opcodes 11x have no ALU function; their result is forced to zero.
    function automatic logic op_invalid(input logic [2:0] op);
        return op[2:1] == 2'b11;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Drives the combinational ALU for one operation per start/done handshake.
// Operands are held stable while the divider pipeline runs, then the
// ALU result is captured into res alongside a div_zero flag.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int DIV_LAT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] res,
    output logic             div_zero,
    output logic [2:0]       alu_s,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_diven,
    input  logic [WIDTH-1:0] alu_result
);

    localparam int CW = $clog2(DIV_LAT) + 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          div_real;

    // A divide only engages the divider when the divisor is non-zero.
    assign div_real = (op == OP_DIV) && (opa != '0);

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        busy      = (state != ST_IDLE);
        done      = (state == ST_DONE);
        case (state)
            ST_IDLE: if (start) state_nxt = div_real ? ST_DIVW : ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DIVW: if (cnt == '0) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Operand latch, divider enable/countdown and result capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            res       <= '0;
            div_zero  <= 1'b0;
            alu_s     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_diven <= 1'b0;
            cnt       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        alu_s <= op;
                        alu_a <= opa;
                        alu_b <= opb;
                        if (div_real) begin
                            alu_diven <= 1'b1;
                            cnt       <= CW'(DIV_LAT - 1);
                        end
                    end
                end
                ST_EXEC: begin
                    // A divide reaching EXEC always had a zero divisor.
                    res      <= (op_invalid(alu_s) || alu_s == OP_DIV) ? '0 : alu_result;
                    div_zero <= (alu_s == OP_DIV);
                end
                ST_DIVW: begin
                    if (cnt == '0) begin
                        res       <= alu_result;
                        div_zero  <= 1'b0;
                        alu_diven <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: a behavioural ALU (with a pipelined divider)
// stands in for the parent's ALU; a transaction-level model predicts every
// output each cycle, and directed vectors carry hand-computed results.
module tb_alu_sequencer;

    localparam int WIDTH   = 16;
    localparam int DIV_LAT = 4;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             start = 1'b0;
    logic [2:0]       op    = 3'b000;
    logic [WIDTH-1:0] opa   = '0;
    logic [WIDTH-1:0] opb   = '0;
    logic             busy, done, div_zero, alu_diven;
    logic [WIDTH-1:0] res, alu_a, alu_b, alu_result;
    logic [2:0]       alu_s;

    int n_cmp = 0;
    int n_err = 0;
    bit run   = 1'b0;

    alu_sequencer #(.WIDTH(WIDTH), .DIV_LAT(DIV_LAT)) dut (
        .clock(clock), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .res(res), .div_zero(div_zero),
        .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_diven(alu_diven),
        .alu_result(alu_result)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural ALU ----------------
    // Divider: result appears after DIV_LAT enabled edges counting the capture edge.
    logic [WIDTH-1:0] qc, dq1, dq2, dq3;
    initial begin dq1 = 16'h1111; dq2 = 16'h2222; dq3 = 16'h3333; end
    assign qc = (alu_a == '0) ? '0 : WIDTH'($signed(alu_b) / $signed(alu_a));
    always @(posedge clock) if (alu_diven) begin dq1 <= qc; dq2 <= dq1; dq3 <= dq2; end
    always_comb begin
        alu_result = 16'hDEAD;
        case (alu_s)
            3'd0: alu_result = alu_a + alu_b;
            3'd1: alu_result = alu_a - alu_b;
            3'd2: alu_result = WIDTH'(alu_a * alu_b);
            3'd3: alu_result = dq3;
            3'd4: alu_result = (alu_b >= 16'd16) ? '0 : (alu_a << alu_b[3:0]);
            3'd5: alu_result = ~(alu_a & alu_b);
            default: alu_result = 16'hDEAD;
        endcase
    end

    // ---------------- reference model ----------------
    function automatic logic [WIDTH-1:0] ref_res(input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        case (o)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return WIDTH'(a * b);
            3'd3: return (a == '0) ? '0 : WIDTH'($signed(b) / $signed(a));
            3'd4: return (b >= 16'd16) ? '0 : (a << b[3:0]);
            3'd5: return ~(a & b);
            default: return '0;
        endcase
    endfunction

    // Transaction view: edges elapsed since accept, against the op's latency.
    bit               m_idle, m_div, m_pdz, m_dz;
    int               m_edges, m_lat;
    logic [WIDTH-1:0] m_pres, m_res, m_a, m_b;
    logic [2:0]       m_s;

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_idle <= 1'b1; m_div <= 1'b0; m_pdz <= 1'b0; m_dz <= 1'b0;
            m_edges <= 0; m_lat <= 2; m_pres <= '0; m_res <= '0;
            m_s <= '0; m_a <= '0; m_b <= '0;
        end else if (m_idle) begin
            if (start) begin
                m_idle  <= 1'b0;
                m_edges <= 1;
                m_s <= op; m_a <= opa; m_b <= opb;
                m_div   <= (op == 3'd3) && (opa != '0);
                m_lat   <= ((op == 3'd3) && (opa != '0)) ? DIV_LAT + 1 : 2;
                m_pres  <= ref_res(op, opa, opb);
                m_pdz   <= (op == 3'd3) && (opa == '0);
            end
        end else begin
            if (m_edges + 1 == m_lat) begin m_res <= m_pres; m_dz <= m_pdz; end
            if (m_edges == m_lat) m_idle <= 1'b1;
            m_edges <= m_edges + 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (run && !reset) begin
            chk("cmp busy",     32'(busy),      32'(!m_idle));
            chk("cmp done",     32'(done),      32'(!m_idle && m_edges == m_lat));
            chk("cmp diven",    32'(alu_diven), 32'(!m_idle && m_div && m_edges < m_lat));
            chk("cmp res",      32'(res),       32'(m_res));
            chk("cmp div_zero", 32'(div_zero),  32'(m_dz));
            chk("cmp alu_s",    32'(alu_s),     32'(m_s));
            chk("cmp alu_a",    32'(alu_a),     32'(m_a));
            chk("cmp alu_b",    32'(alu_b),     32'(m_b));
        end
    end

    // mode 0: single-cycle start; 1: start held and operands scrambled; 2: extra start pulse while busy
    task automatic run_op(input string nm, input logic [2:0] o, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic [WIDTH-1:0] er, input logic edz, input int elat, input int mode);
        int k, ndone, nden;
        bit seen;
        logic [WIDTH-1:0] r;
        logic dz;
        r = '0; dz = 1'b0;
        @(negedge clock);
        start = 1'b1; op = o; opa = a; opb = b;
        @(negedge clock);
        k = 1; ndone = 0; nden = 0; seen = 1'b0;
        if (mode != 1) start = 1'b0;
        else begin op = 3'b110; opa = 16'hFFFF; opb = 16'h1234; end
        while (!seen && k <= 20) begin
            if (alu_diven) nden++;
            if (mode == 2 && k == 2) start = 1'b1;
            if (mode == 2 && k == 3) start = 1'b0;
            if (done) begin
                seen = 1'b1; ndone++; r = res; dz = div_zero; start = 1'b0;
            end else begin
                @(negedge clock); k++;
            end
        end
        if (!seen) begin
            chk({nm, " timeout"}, 32'd0, 32'd1);
            start = 1'b0;
            return;
        end
        chk({nm, " latency"},  32'(k),     32'(elat));
        chk({nm, " res"},      32'(r),     32'(er));
        chk({nm, " div_zero"}, 32'(dz),    32'(edz));
        chk({nm, " diven"},    32'(nden),  32'((elat > 2) ? elat - 1 : 0));
        repeat (3) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk({nm, " dones"},    32'(ndone), 32'd1);
    endtask

    initial begin
        int nd;
        #3 reset = 1'b1;
        #1;
        chk("rst busy", 32'(busy), 0);      chk("rst done", 32'(done), 0);
        chk("rst res", 32'(res), 0);        chk("rst div_zero", 32'(div_zero), 0);
        chk("rst alu_s", 32'(alu_s), 0);    chk("rst alu_a", 32'(alu_a), 0);
        chk("rst alu_b", 32'(alu_b), 0);    chk("rst diven", 32'(alu_diven), 0);
        @(negedge clock);
        reset = 1'b0;
        run   = 1'b1;

        run_op("add",     3'd0, 16'd7,    16'd5,    16'd12,    1'b0, 2, 0);
        run_op("sub",     3'd1, 16'd20,   16'd7,    16'd13,    1'b0, 2, 0);
        run_op("mul",     3'd2, 16'd300,  16'd300,  16'd24464, 1'b0, 2, 0);
        run_op("nand",    3'd5, 16'hF0F0, 16'hFF00, 16'h0FFF,  1'b0, 2, 0);
        run_op("inv110",  3'd6, 16'd1,    16'd2,    16'h0000,  1'b0, 2, 0);
        run_op("inv111",  3'd7, 16'd9,    16'd3,    16'h0000,  1'b0, 2, 0);
        run_op("div",     3'd3, 16'd3,    16'hFFF6, 16'hFFFD,  1'b0, 5, 0);
        run_op("divzero", 3'd3, 16'd0,    16'd9,    16'h0000,  1'b1, 2, 0);
        run_op("shl_neg", 3'd4, 16'h0001, 16'hFFFF, 16'h0000,  1'b0, 2, 0);
        run_op("shl4",    3'd4, 16'h0001, 16'd4,    16'h0010,  1'b0, 2, 0);
        run_op("divhold", 3'd3, 16'd7,    16'd100,  16'd14,    1'b0, 5, 1);
        run_op("divpulse",3'd3, 16'hFFFC, 16'd50,   16'hFFF4,  1'b0, 5, 2);

        // Reset during the second DIVW cycle discards the divide.
        @(negedge clock);
        start = 1'b1; op = 3'd3; opa = 16'd3; opb = 16'd100;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midrst busy", 32'(busy), 0);      chk("midrst done", 32'(done), 0);
        chk("midrst res", 32'(res), 0);        chk("midrst div_zero", 32'(div_zero), 0);
        chk("midrst alu_s", 32'(alu_s), 0);    chk("midrst alu_a", 32'(alu_a), 0);
        chk("midrst alu_b", 32'(alu_b), 0);    chk("midrst diven", 32'(alu_diven), 0);
        @(negedge clock);
        reset = 1'b0;
        nd = 0;
        repeat (8) begin
            @(negedge clock);
            if (done) nd++;
        end
        chk("midrst no done", 32'(nd), 0);
        run_op("div_after_rst", 3'd3, 16'd2, 16'd8, 16'd4, 1'b0, 5, 0);

        repeat (2) @(negedge clock);
        run = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
